// File: rtl/trigger_manager_multi.sv
// trigger_manager_multi
// Fill trigger manager for the digitizer front-end. Each trigger starts a fill
// that drives go to the enabled channels. The fill ends when every enabled
// channel reports done, or when the optional timeout expires. The resulting
// fill record is then offered to a downstream FIFO. Triggers that arrive while
// a fill is running are queued up to PEND_MAX deep. Triggers beyond that depth
// are counted as dropped.
module trigger_manager_multi #(
   parameter int NUM_CHAN  = 5,
   parameter int FILLNUM_W = 24,
   parameter int TIMEOUT_W = 16,
   parameter int PEND_MAX  = 3,
   parameter int DROP_W    = 16,
   localparam int PEND_W   = $clog2(PEND_MAX + 1),
   localparam int REC_W    = FILLNUM_W + NUM_CHAN + 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 trigger,
   input  logic [NUM_CHAN-1:0]  chan_enable,
   input  logic [TIMEOUT_W-1:0] timeout_cycles,
   input  logic [NUM_CHAN-1:0]  done,
   output logic [NUM_CHAN-1:0]  go,
   output logic                 fifo_valid,
   input  logic                 fifo_ready,
   output logic [REC_W-1:0]     fifo_data,
   output logic [FILLNUM_W-1:0] fillNum,
   output logic [PEND_W-1:0]    pending,
   output logic [DROP_W-1:0]    dropped_count,
   output logic                 busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_STORE = 2'd2
   } state_t;

   localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);
   localparam logic [DROP_W-1:0] DROP_SAT  = {DROP_W{1'b1}};

   state_t               state_r;
   logic [NUM_CHAN-1:0]  en_lat_r;
   logic [TIMEOUT_W-1:0] timer_r;
   logic [NUM_CHAN-1:0]  go_r;
   logic                 fifo_valid_r;
   logic [REC_W-1:0]     fifo_data_r;
   logic [FILLNUM_W-1:0] fillnum_r;
   logic [PEND_W-1:0]    pending_r;
   logic [DROP_W-1:0]    dropped_r;
   logic                 busy_r;

   logic                 start_s;
   logic                 enqueue_s;
   logic                 dequeue_s;
   logic                 complete_s;
   logic                 expire_s;
   logic [NUM_CHAN-1:0]  snapshot_s;
   logic [PEND_W-1:0]    pending_nxt_s;
   logic                 drop_s;

   // Decode fill start, completion, timeout and queue push/pop events.
   always_comb begin
      start_s    = 1'b0;
      enqueue_s  = 1'b0;
      dequeue_s  = 1'b0;
      snapshot_s = done & en_lat_r;
      complete_s = (snapshot_s == en_lat_r);
      expire_s   = (timeout_cycles != TIMEOUT_W'(0)) &&
                   (timer_r == (timeout_cycles - TIMEOUT_W'(1)));
      if (state_r == ST_IDLE) begin
         // The queue is served first. A trigger in the same cycle is queued behind it.
         start_s   = trigger | (pending_r != PEND_W'(0));
         dequeue_s = (pending_r != PEND_W'(0));
         enqueue_s = trigger & (pending_r != PEND_W'(0));
      end else begin
         enqueue_s = trigger;
      end
   end

   // Compute the next pending depth and whether an incoming trigger is lost.
   always_comb begin
      pending_nxt_s = pending_r;
      drop_s        = 1'b0;
      if (enqueue_s && dequeue_s) begin
         pending_nxt_s = pending_r;
      end else if (enqueue_s) begin
         if (pending_r == PEND_FULL) begin
            drop_s = 1'b1;
         end else begin
            pending_nxt_s = pending_r + PEND_W'(1);
         end
      end else if (dequeue_s) begin
         pending_nxt_s = pending_r - PEND_W'(1);
      end else begin
         pending_nxt_s = pending_r;
      end
   end

   // Pending queue depth and saturating dropped-trigger counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_r <= PEND_W'(0);
         dropped_r <= DROP_W'(0);
      end else begin
         pending_r <= pending_nxt_s;
         if (drop_s && (dropped_r != DROP_SAT)) begin
            dropped_r <= dropped_r + DROP_W'(1);
         end
      end
   end

   // Fill sequencing: IDLE -> FILL -> STORE -> IDLE. All outputs are registered.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r      <= ST_IDLE;
         en_lat_r     <= NUM_CHAN'(0);
         timer_r      <= TIMEOUT_W'(0);
         go_r         <= NUM_CHAN'(0);
         fifo_valid_r <= 1'b0;
         fifo_data_r  <= REC_W'(0);
         fillnum_r    <= FILLNUM_W'(0);
         busy_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r   <= ST_FILL;
                  fillnum_r <= fillnum_r + FILLNUM_W'(1);
                  en_lat_r  <= chan_enable;
                  go_r      <= chan_enable;
                  timer_r   <= TIMEOUT_W'(0);
                  busy_r    <= 1'b1;
               end
            end
            ST_FILL: begin
               // Completion has priority over a timeout in the same cycle.
               if (complete_s) begin
                  state_r      <= ST_STORE;
                  go_r         <= NUM_CHAN'(0);
                  fifo_valid_r <= 1'b1;
                  fifo_data_r  <= {1'b0, snapshot_s, fillnum_r};
               end else if (expire_s) begin
                  state_r      <= ST_STORE;
                  go_r         <= NUM_CHAN'(0);
                  fifo_valid_r <= 1'b1;
                  fifo_data_r  <= {1'b1, snapshot_s, fillnum_r};
               end else begin
                  timer_r <= timer_r + TIMEOUT_W'(1);
               end
            end
            ST_STORE: begin
               // The record stays on fifo_data until the downstream FIFO accepts it.
               if (fifo_ready) begin
                  state_r      <= ST_IDLE;
                  fifo_valid_r <= 1'b0;
                  busy_r       <= 1'b0;
               end
            end
            default: begin
               state_r      <= ST_IDLE;
               go_r         <= NUM_CHAN'(0);
               fifo_valid_r <= 1'b0;
               busy_r       <= 1'b0;
            end
         endcase
      end
   end

   assign go            = go_r;
   assign fifo_valid    = fifo_valid_r;
   assign fifo_data     = fifo_data_r;
   assign fillNum       = fillnum_r;
   assign pending       = pending_r;
   assign dropped_count = dropped_r;
   assign busy          = busy_r;

endmodule

// File: tb/tb_trigger_manager_multi.sv
// Testbench for trigger_manager_multi. It checks a default-parameter instance and
// a narrow instance (3-bit fill number, 2-bit drop counter). The narrow instance
// exercises fill-number wrap and drop saturation. Both instances are compared
// every cycle against a transaction-level reference model.
module tb_trigger_manager_multi;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        trigger;
   logic [4:0]  chan_enable;
   logic [15:0] timeout_cycles;
   logic [4:0]  done;
   logic        fifo_ready;

   logic [4:0]  go_b,  go_s;
   logic        val_b, val_s;
   logic [29:0] data_b;
   logic [8:0]  data_s;
   logic [23:0] fn_b;
   logic [2:0]  fn_s;
   logic [1:0]  pend_b, pend_s;
   logic [15:0] drop_b;
   logic [1:0]  drop_s;
   logic        busy_b, busy_s;

   trigger_manager_multi dut (
      .clk(clk), .reset_n(reset_n), .trigger(trigger), .chan_enable(chan_enable),
      .timeout_cycles(timeout_cycles), .done(done), .go(go_b), .fifo_valid(val_b),
      .fifo_ready(fifo_ready), .fifo_data(data_b), .fillNum(fn_b), .pending(pend_b),
      .dropped_count(drop_b), .busy(busy_b)
   );

   trigger_manager_multi #(.FILLNUM_W(3), .DROP_W(2)) dut_n (
      .clk(clk), .reset_n(reset_n), .trigger(trigger), .chan_enable(chan_enable),
      .timeout_cycles(timeout_cycles), .done(done), .go(go_s), .fifo_valid(val_s),
      .fifo_ready(fifo_ready), .fifo_data(data_s), .fillNum(fn_s), .pending(pend_s),
      .dropped_count(drop_s), .busy(busy_s)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_no = 0;

   // Reference model: the fill phase, a queue of waiting triggers, and running totals.
   typedef enum {M_IDLE, M_FILL, M_STORE} mode_t;
   mode_t      m_mode;
   int         q[$];
   int         m_fills;
   int         m_drops;
   int         m_start;
   logic [4:0] m_en;
   logic       m_flag;
   logic [4:0] m_snap;
   int         m_rec_fill;

   logic [4:0]  g_en;
   logic [15:0] g_tmo;
   logic [4:0]  g_dn;
   logic        g_rdy;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_no, got, exp);
      end
   endtask

   function automatic void queue_trigger(input bit trg);
      if (trg) begin
         if (q.size() < 3) q.push_back(cyc_no);
         else m_drops++;
      end
   endfunction

   function automatic void model_step(input bit trg, input logic [4:0] en, input logic [15:0] tmo,
                                      input logic [4:0] dn, input bit rdy, input bit rst);
      int fill_cycles;
      if (!rst) begin
         m_mode = M_IDLE; q.delete(); m_fills = 0; m_drops = 0; m_start = 0;
         m_en = 5'd0; m_flag = 1'b0; m_snap = 5'd0; m_rec_fill = 0;
         return;
      end
      case (m_mode)
         M_IDLE: begin
            bit serve = trg || (q.size() > 0);
            if (q.size() > 0) begin
               void'(q.pop_front());
               if (trg) q.push_back(cyc_no);
            end
            if (serve) begin
               m_fills++;
               m_en    = en;
               m_start = cyc_no + 1;
               m_mode  = M_FILL;
            end
         end
         M_FILL: begin
            queue_trigger(trg);
            fill_cycles = cyc_no - m_start + 1;
            if ((dn & m_en) == m_en) begin
               m_flag = 1'b0; m_snap = dn & m_en; m_rec_fill = m_fills; m_mode = M_STORE;
            end else if ((tmo != 16'd0) && (fill_cycles == int'(tmo))) begin
               m_flag = 1'b1; m_snap = dn & m_en; m_rec_fill = m_fills; m_mode = M_STORE;
            end
         end
         default: begin
            queue_trigger(trg);
            if (rdy) m_mode = M_IDLE;
         end
      endcase
   endfunction

   task automatic compare_all();
      logic [29:0] exp_b;
      logic [8:0]  exp_s;
      logic [4:0]  exp_go;
      int          db, ds;
      exp_go = (m_mode == M_FILL) ? m_en : 5'd0;
      exp_b  = {m_flag, m_snap, m_rec_fill[23:0]};
      exp_s  = {m_flag, m_snap, m_rec_fill[2:0]};
      db     = (m_drops > 65535) ? 65535 : m_drops;
      ds     = (m_drops > 3) ? 3 : m_drops;
      check_eq("go",        64'(go_b),   64'(exp_go));
      check_eq("valid",     64'(val_b),  64'(m_mode == M_STORE));
      check_eq("data",      64'(data_b), 64'(exp_b));
      check_eq("fillNum",   64'(fn_b),   64'(m_fills % (1 << 24)));
      check_eq("pending",   64'(pend_b), 64'(q.size()));
      check_eq("dropped",   64'(drop_b), 64'(db));
      check_eq("busy",      64'(busy_b), 64'(m_mode != M_IDLE));
      check_eq("n_go",      64'(go_s),   64'(exp_go));
      check_eq("n_valid",   64'(val_s),  64'(m_mode == M_STORE));
      check_eq("n_data",    64'(data_s), 64'(exp_s));
      check_eq("n_fillNum", 64'(fn_s),   64'(m_fills % 8));
      check_eq("n_pending", 64'(pend_s), 64'(q.size()));
      check_eq("n_dropped", 64'(drop_s), 64'(ds));
      check_eq("n_busy",    64'(busy_s), 64'(m_mode != M_IDLE));
   endtask

   task automatic cyc(input bit trg, input logic [4:0] en, input logic [15:0] tmo,
                      input logic [4:0] dn, input bit rdy, input bit rst);
      trigger = trg; chan_enable = en; timeout_cycles = tmo; done = dn;
      fifo_ready = rdy; reset_n = rst;
      model_step(trg, en, tmo, dn, rdy, rst);
      @(posedge clk);
      cyc_no++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic step(input bit trg);
      cyc(trg, g_en, g_tmo, g_dn, g_rdy, 1'b1);
   endtask

   initial begin
      logic [29:0] rec_exp;
      int k;
      // Reset
      cyc(1'b0, 5'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      cyc(1'b0, 5'd0, 16'd0, 5'd0, 1'b0, 1'b0);
      check_eq("reset_valid", 64'(val_b), 64'd0);
      check_eq("reset_fillNum", 64'(fn_b), 64'd0);

      // Basic fill, all channels enabled, no timeout
      g_en = 5'b11111; g_tmo = 16'd0; g_dn = 5'd0; g_rdy = 1'b0;
      step(1'b0); step(1'b0);
      step(1'b1);
      check_eq("basic_go", 64'(go_b), 64'h1f);
      repeat (9) step(1'b0);
      g_dn = 5'b11111;
      step(1'b0);
      rec_exp = {1'b0, 5'b11111, 24'd1};
      check_eq("basic_valid", 64'(val_b), 64'd1);
      check_eq("basic_rec", 64'(data_b), 64'(rec_exp));
      g_dn = 5'd0;
      step(1'b0);
      g_rdy = 1'b1;
      step(1'b0);
      check_eq("basic_idle", 64'(busy_b), 64'd0);

      // Channel masking
      g_en = 5'b00101; g_dn = 5'b00101;
      step(1'b1);
      check_eq("mask_go", 64'(go_b), 64'h05);
      step(1'b0);
      check_eq("mask_snap", 64'(data_b[28:24]), 64'h05);
      step(1'b0);
      // No channels enabled: the record appears two cycles after the trigger
      g_en = 5'd0; g_dn = 5'd0;
      step(1'b1);
      step(1'b0);
      check_eq("en0_valid", 64'(val_b), 64'd1);
      step(1'b0);

      // Timeout after 8 fill cycles with partial done
      g_en = 5'b11111; g_dn = 5'b00011; g_tmo = 16'd8;
      step(1'b1);
      k = 0;
      while (k < 20 && val_b !== 1'b1) begin
         step(1'b0);
         k++;
      end
      check_eq("tmo_cycles", 64'(k), 64'd8);
      check_eq("tmo_flag", 64'(data_b[29]), 64'd1);
      check_eq("tmo_snap", 64'(data_b[28:24]), 64'h03);
      step(1'b0);
      // Completion on the eighth cycle wins over the timeout
      step(1'b1);
      repeat (7) step(1'b0);
      g_dn = 5'b11111;
      step(1'b0);
      check_eq("tmo_tie_flag", 64'(data_b[29]), 64'd0);
      step(1'b0);

      // Queueing: five triggers during one fill
      g_tmo = 16'd0; g_dn = 5'd0;
      step(1'b1);
      repeat (5) step(1'b1);
      check_eq("q_pending", 64'(pend_b), 64'd3);
      check_eq("q_dropped", 64'(drop_b), 64'd2);
      g_dn = 5'b11111;
      repeat (16) step(1'b0);
      check_eq("q_drained", 64'(pend_b), 64'd0);

      // Backpressure: ready low for 100 cycles
      g_rdy = 1'b0;
      step(1'b1);
      step(1'b0);
      repeat (100) step(1'b0);
      check_eq("bp_valid", 64'(val_b), 64'd1);
      g_rdy = 1'b1;
      step(1'b0);

      // Reset mid-fill with two triggers pending
      g_dn = 5'd0;
      step(1'b1); step(1'b1); step(1'b1);
      check_eq("rst_pend_pre", 64'(pend_b), 64'd2);
      cyc(1'b0, g_en, g_tmo, g_dn, g_rdy, 1'b0);
      check_eq("rst_go", 64'(go_b), 64'd0);
      check_eq("rst_pend", 64'(pend_b), 64'd0);
      step(1'b0);
      step(1'b1);
      check_eq("rst_fillNum", 64'(fn_b), 64'd1);
      g_dn = 5'b11111;
      step(1'b0); step(1'b0);

      // Randomized traffic
      for (int seg = 0; seg < 8; seg++) begin
         case ($urandom_range(0, 4))
            0: g_tmo = 16'd0;
            1: g_tmo = 16'd1;
            2: g_tmo = 16'd2;
            3: g_tmo = 16'd5;
            default: g_tmo = 16'd8;
         endcase
         for (int i = 0; i < 400; i++) begin
            logic [4:0] dn_r;
            dn_r = ($urandom_range(0, 3) == 0) ? 5'h1f : 5'($urandom);
            cyc(($urandom_range(0, 4) == 0), 5'($urandom), g_tmo, dn_r,
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 399) != 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
